half_adder: RTL and testbench
=============================

# half_adder

Half adder with a registered output stage. For each lane it computes the sum (XOR) and carry (AND) of two one-bit operands. It is the leaf building block of the full adder: two half adders plus an OR of their carries form a full adder, and wider adders are built from those. Per-lane operation and a valid flag let it be used either as a scalar cell or as a bank of independent lanes.

## Interface
Parameters:
- WIDTH, default 1: number of independent half-adder lanes. Legal range is 1 to 64.
- REG_OUT, default 1: 1 means outputs are registered (1-cycle latency). 0 means sum and carry are purely combinational, and clk/rst affect only out_valid.

Ports:
- clk  input  1  clock. All state updates on its rising edge.
- rst  input  1  reset. Synchronous and active-high.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  a and b carry a new operation this cycle.
- sum  output  WIDTH  per-lane a XOR b.
- carry  output  WIDTH  per-lane a AND b.
- out_valid  output  1  sum and carry hold the result of a valid operation.

## Operation
- Lane i computes sum[i] = a[i] ^ b[i] and carry[i] = a[i] & b[i]. Lanes never interact; there is no carry propagation between lanes.
- Truth table per lane (a,b -> sum,carry): 0,0 -> 0,0; 0,1 -> 1,0; 1,0 -> 1,0; 1,1 -> 0,1.
- Invariant: for every lane, 2*carry + sum = a + b. sum and carry are never both 1.
- REG_OUT=1:
  - On a clk edge with rst=0 and in_valid=1, the sum and carry registers capture the lane results and out_valid is set to 1.
  - On a clk edge with rst=0 and in_valid=0, sum and carry hold their previous values and out_valid is set to 0.
- REG_OUT=0:
  - sum and carry follow a and b combinationally, independent of in_valid.
  - out_valid is in_valid registered by one cycle. It exists only to keep the interface uniform.
- X or Z on a or b is not sanitised; it propagates to the affected lane only.

## Timing
- Reset: on a clk edge with rst=1, sum=0, carry=0 and out_valid=0 (all lanes). This applies for any value of in_valid or the operands, because rst has priority.
- Reset asserted mid-stream: the operation presented in the same cycle is discarded. The first post-reset result appears one edge after the first cycle with rst=0 and in_valid=1.
- REG_OUT=1 latency is exactly 1 clk:
  - Operands sampled at edge N produce results visible after edge N until the next update.
  - Back-to-back valid inputs give one result per cycle. Throughput is 1 operation per clk.
  - There is no backpressure and no ready signal.
- REG_OUT=0 latency is 0 for sum and carry; combinational settling only.
- The first cycle after rst deasserts produces no result unless in_valid=1 on that edge.

## Test plan
- Exhaustive scalar check (WIDTH=1, REG_OUT=1):
  - Stimulus: apply (a,b) = 00, 01, 10, 11 with in_valid=1 on consecutive edges.
  - Required response, one cycle later: (sum,carry) = (0,0), (1,0), (1,0), (0,1), with out_valid=1 on each.
- Multi-lane (WIDTH=4):
  - Stimulus: a=4'b1100, b=4'b1010, in_valid=1.
  - Required response on the next cycle: sum=4'b0110, carry=4'b1000.
- Hold behaviour:
  - Stimulus: load a=1, b=1, then drop in_valid and set a=0, b=1 for 3 cycles.
  - Required response: sum=0 and carry=1 are held, out_valid=0.
- Reset priority:
  - Stimulus: assert rst in the same cycle as in_valid=1, a=1, b=0.
  - Required response: the next edge gives sum=0, carry=0, out_valid=0. Deassert rst, apply a=1, b=0 with in_valid=1, and the result is sum=1 after one edge.
- Full-adder composition (REG_OUT=0):
  - Structure: the first instance adds a and b; the second adds its sum to cin; the two carries are ORed.
  - Stimulus: sweep {a,b,cin} = 0 to 7.
  - Required response: outputs match a+b+cin, e.g. 3'b111 -> sum=1, carry=1 and 3'b110 -> sum=0, carry=1.

Source files
------------

// File: rtl/half_adder.sv
// Bank of independent half-adder lanes (sum = a ^ b, carry = a & b), optionally registered.
// Latency 1 clk when REG_OUT=1, 0 when REG_OUT=0; no backpressure, one op per clk.
module half_adder #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             r_out_valid;

  // Lanes are fully independent: no carry ripples between bit positions.
  assign w_sum   = a ^ b;
  assign w_carry = a & b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  assign out_valid = r_out_valid;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_carry;

      // Results hold while in_valid is low so the last answer stays readable.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum   <= '0;
          r_carry <= '0;
        end else if (in_valid) begin
          r_sum   <= w_sum;
          r_carry <= w_carry;
        end
      end

      assign sum   = r_sum;
      assign carry = r_carry;
    end else begin : g_comb
      assign sum   = w_sum;
      assign carry = w_carry;
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: scalar, 4-lane and full-adder composition instances.
module tb_half_adder;

  typedef struct packed {
    logic [3:0] sum;
    logic [3:0] carry;
    logic       vld;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic s_a, s_b, s_vld;
  logic s_sum, s_carry, s_ov;

  logic [3:0] wd_a, wd_b;
  logic       wd_vld;
  logic [3:0] wd_sum, wd_carry;
  logic       wd_ov;

  logic f_a, f_b, f_cin, f_vld;
  logic f_s1, f_c1, f_ov1;
  logic f_s2, f_c2, f_ov2;

  res_t q[$];
  res_t got, exp_r;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Truth-table constants indexed by {a,b}.
  logic [3:0] tbl_s = 4'b0110;
  logic [3:0] tbl_c = 4'b1000;

  half_adder #(.WIDTH(1), .REG_OUT(1)) u_scalar (
    .clk(clk), .rst(rst), .a(s_a), .b(s_b), .in_valid(s_vld),
    .sum(s_sum), .carry(s_carry), .out_valid(s_ov)
  );

  half_adder #(.WIDTH(4), .REG_OUT(1)) u_wide (
    .clk(clk), .rst(rst), .a(wd_a), .b(wd_b), .in_valid(wd_vld),
    .sum(wd_sum), .carry(wd_carry), .out_valid(wd_ov)
  );

  half_adder #(.WIDTH(1), .REG_OUT(0)) u_fa_h1 (
    .clk(clk), .rst(rst), .a(f_a), .b(f_b), .in_valid(f_vld),
    .sum(f_s1), .carry(f_c1), .out_valid(f_ov1)
  );

  half_adder #(.WIDTH(1), .REG_OUT(0)) u_fa_h2 (
    .clk(clk), .rst(rst), .a(f_s1), .b(f_cin), .in_valid(f_vld),
    .sum(f_s2), .carry(f_c2), .out_valid(f_ov2)
  );

  task automatic test_reset();
    rst = 1'b1;
    s_a = 1'b1; s_b = 1'b1; s_vld = 1'b1;
    wd_a = 4'hF; wd_b = 4'hF; wd_vld = 1'b1;
    f_a = 1'b0; f_b = 1'b0; f_cin = 1'b0; f_vld = 1'b1;
    q.push_back('{sum: 4'h0, carry: 4'h0, vld: 1'b0});
    q.push_back('{sum: 4'h0, carry: 4'h0, vld: 1'b0});
    q.push_back('{sum: 4'h0, carry: 4'h0, vld: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    exp_r = q.pop_front();
    got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL reset_scalar got=%h want=%h", got, exp_r);
    end
    exp_r = q.pop_front();
    got = '{sum: wd_sum, carry: wd_carry, vld: wd_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL reset_wide got=%h want=%h", got, exp_r);
    end
    exp_r = q.pop_front();
    n_cmp++;
    if ({f_ov1, f_ov2} !== {exp_r.vld, exp_r.vld}) begin
      n_bad++;
      $display("FAIL reset_fa_valid got=%b%b want=%b", f_ov1, f_ov2, exp_r.vld);
    end
    rst = 1'b0;
    f_vld = 1'b0;
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 4; v++) begin
      s_a = v[1]; s_b = v[0]; s_vld = 1'b1;
      q.push_back('{sum: {3'b0, tbl_s[v]}, carry: {3'b0, tbl_c[v]}, vld: 1'b1});
      @(posedge clk); #1;
      exp_r = q.pop_front();
      got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
      n_cmp++;
      if (got !== exp_r) begin
        n_bad++;
        $display("FAIL exhaustive ab=%0d got=%h want=%h", v, got, exp_r);
      end
    end
  endtask

  task automatic test_lanes();
    logic [3:0] es, ec;
    wd_a = 4'b1100; wd_b = 4'b1010; wd_vld = 1'b1;
    q.push_back('{sum: 4'b0110, carry: 4'b1000, vld: 1'b1});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: wd_sum, carry: wd_carry, vld: wd_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL lanes_fixed got=%h want=%h", got, exp_r);
    end
    // Back-to-back random operands, one result per clock.
    for (int k = 0; k < 8; k++) begin
      wd_a = 4'($urandom_range(0, 15));
      wd_b = 4'($urandom_range(0, 15));
      wd_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
        es[i] = tbl_s[{wd_a[i], wd_b[i]}];
        ec[i] = tbl_c[{wd_a[i], wd_b[i]}];
      end
      q.push_back('{sum: es, carry: ec, vld: 1'b1});
      @(posedge clk); #1;
      exp_r = q.pop_front();
      got = '{sum: wd_sum, carry: wd_carry, vld: wd_ov};
      n_cmp++;
      if (got !== exp_r) begin
        n_bad++;
        $display("FAIL lanes_b2b k=%0d a=%h b=%h got=%h want=%h", k, wd_a, wd_b, got, exp_r);
      end
    end
    // A bubble holds the wide result and drops out_valid.
    wd_vld = 1'b0; wd_a = ~wd_a;
    q.push_back('{sum: es, carry: ec, vld: 1'b0});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: wd_sum, carry: wd_carry, vld: wd_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL lanes_hold got=%h want=%h", got, exp_r);
    end
  endtask

  task automatic test_hold();
    s_a = 1'b1; s_b = 1'b1; s_vld = 1'b1;
    q.push_back('{sum: 4'h0, carry: 4'h1, vld: 1'b1});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL hold_load got=%h want=%h", got, exp_r);
    end
    s_vld = 1'b0; s_a = 1'b0; s_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q.push_back('{sum: 4'h0, carry: 4'h1, vld: 1'b0});
      @(posedge clk); #1;
      exp_r = q.pop_front();
      got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
      n_cmp++;
      if (got !== exp_r) begin
        n_bad++;
        $display("FAIL hold_cycle%0d got=%h want=%h", k, got, exp_r);
      end
    end
  endtask

  task automatic test_reset_priority();
    s_a = 1'b1; s_b = 1'b0; s_vld = 1'b1;
    q.push_back('{sum: 4'h1, carry: 4'h0, vld: 1'b1});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL rstprio_preload got=%h want=%h", got, exp_r);
    end
    rst = 1'b1;
    q.push_back('{sum: 4'h0, carry: 4'h0, vld: 1'b0});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL rstprio_reset got=%h want=%h", got, exp_r);
    end
    rst = 1'b0; s_vld = 1'b0;
    q.push_back('{sum: 4'h0, carry: 4'h0, vld: 1'b0});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL rstprio_idle got=%h want=%h", got, exp_r);
    end
    s_vld = 1'b1;
    q.push_back('{sum: 4'h1, carry: 4'h0, vld: 1'b1});
    @(posedge clk); #1;
    exp_r = q.pop_front();
    got = '{sum: {3'b0, s_sum}, carry: {3'b0, s_carry}, vld: s_ov};
    n_cmp++;
    if (got !== exp_r) begin
      n_bad++;
      $display("FAIL rstprio_resume got=%h want=%h", got, exp_r);
    end
    s_vld = 1'b0;
  endtask

  task automatic test_full_adder();
    int total;
    f_vld = 1'b0;
    for (int v = 0; v < 8; v++) begin
      f_a = v[2]; f_b = v[1]; f_cin = v[0];
      total = v[2] + v[1] + v[0];
      q.push_back('{sum: {3'b0, total[0]}, carry: {3'b0, total[1]}, vld: 1'b0});
      @(negedge clk);
      exp_r = q.pop_front();
      got = '{sum: {3'b0, f_s2}, carry: {3'b0, f_c1 | f_c2}, vld: f_ov2};
      n_cmp++;
      if (got !== exp_r) begin
        n_bad++;
        $display("FAIL full_adder abc=%0d got=%h want=%h", v, got, exp_r);
      end
    end
    f_vld = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({f_ov1, f_ov2} !== 2'b11) begin
      n_bad++;
      $display("FAIL fa_out_valid got=%b%b want=11", f_ov1, f_ov2);
    end
    f_vld = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({f_ov1, f_ov2} !== 2'b00) begin
      n_bad++;
      $display("FAIL fa_out_valid_drop got=%b%b want=00", f_ov1, f_ov2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exhaustive();
    test_lanes();
    test_hold();
    test_reset_priority();
    test_full_adder();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
